fifo_stream_reader: RTL and testbench



---
 rtl/fifo_pkg.sv | 17 +
 rtl/stream_buf.sv | 51 +++++
 rtl/fifo_stream_reader.sv | 84 ++++++++
 tb/tb_fifo_stream_reader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: types and defaults shared by the FIFO and its read-side consumers.
//   FIFO_WIDTH      default data word width
//   FIFO_BURST_LEN  default beats per burst
//   state_t         reader FSM state (IDLE, RUN, DRAIN)
//   ptr_width()     pointer width for a buffer of a given depth
package fifo_pkg;

    localparam int FIFO_WIDTH     = 32;
    localparam int FIFO_BURST_LEN = 16;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stream_buf.sv
// stream_buf: DEPTH-entry circular buffer with occupancy count and head output.
//   r_clk      clock
//   r_rst_n    asynchronous active-low reset
//   push       write push_data at tail
//   push_data  word to store
//   pop        advance head (caller guarantees occ != 0)
//   occ        number of stored words
//   head_data  word at head
module stream_buf
    import fifo_pkg::*;
#(
    parameter  int WIDTH = FIFO_WIDTH,
    parameter  int DEPTH = 4,
    localparam int PW    = ptr_width(DEPTH),
    localparam int OW    = $clog2(DEPTH + 1)
) (
    input  logic             r_clk,
    input  logic             r_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [OW-1:0]    occ,
    output logic [WIDTH-1:0] head_data
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    // explicit compare-and-reset so non-power-of-2 depths wrap correctly
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= (tail == LAST) ? '0 : tail + 1'b1;
            end
            if (pop) head <= (head == LAST) ? '0 : head + 1'b1;
            occ <= occ + OW'(push) - OW'(pop);
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a FIFO read port into a valid/ready stream with burst framing.
//   r_clk     read-domain clock
//   r_rst_n   asynchronous active-low reset
//   enable    permits new FIFO reads; buffered/in-flight words still drain
//   empty     FIFO empty flag
//   data_out  FIFO read data, valid the cycle after an accepted RD_EN
//   RD_EN     FIFO read request (combinational, independent of m_ready)
//   m_valid   stream word available
//   m_data    stream data (buffer head)
//   m_last    final beat of the current burst
//   m_ready   downstream accept
//   busy      high unless in IDLE
//   beat_cnt  beat index within the current burst
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter  int WIDTH     = FIFO_WIDTH,
    parameter  int BUF_DEPTH = 4,
    parameter  int BURST_LEN = FIFO_BURST_LEN,
    localparam int OW        = $clog2(BUF_DEPTH + 1),
    localparam int BW        = $clog2(BURST_LEN + 1)
) (
    input  logic             r_clk,
    input  logic             r_rst_n,
    input  logic             enable,
    input  logic             empty,
    input  logic [WIDTH-1:0] data_out,
    output logic             RD_EN,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy,
    output logic [BW-1:0]    beat_cnt
);

    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

    state_t        state;
    logic          inflight;
    logic          pop;
    logic          drained;
    logic [OW-1:0] occ;

    // credit check counts the word still in flight from the FIFO so the
    // buffer can never overflow, without looking at m_ready
    assign RD_EN   = r_rst_n && enable && !empty && ((32'(occ) + 32'(inflight)) < 32'(BUF_DEPTH));
    assign m_valid = (occ != '0);
    assign pop     = m_valid && m_ready;
    assign m_last  = m_valid && (beat_cnt == BEAT_LAST);
    assign busy    = (state != IDLE);
    assign drained = (occ == '0) && !inflight;

    stream_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .r_clk     (r_clk),
        .r_rst_n   (r_rst_n),
        .push      (inflight),
        .push_data (data_out),
        .pop       (pop),
        .occ       (occ),
        .head_data (m_data)
    );

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            state    <= IDLE;
            inflight <= 1'b0;
            beat_cnt <= '0;
        end else begin
            inflight <= RD_EN;
            if (pop) beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + 1'b1;
            case (state)
                IDLE:    if (enable && !empty) state <= RUN;
                RUN:     state <= !enable ? DRAIN : (empty && drained) ? IDLE : RUN;
                DRAIN:   state <= enable ? RUN : drained ? IDLE : DRAIN;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed checks of the FIFO stream reader against a behavioural FIFO.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    localparam int W  = 32;
    localparam int BD = 4;
    localparam int BL = 4;
    localparam int BW = $clog2(BL + 1);

    logic          r_clk   = 1'b0;
    logic          r_rst_n = 1'b0;
    logic          enable  = 1'b0;
    logic          m_ready = 1'b0;
    logic          empty;
    logic          RD_EN;
    logic          m_valid;
    logic          m_last;
    logic          busy;
    logic [W-1:0]  data_out;
    logic [W-1:0]  m_data;
    logic [BW-1:0] beat_cnt;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] fifo_data [2048];
    int           wr_idx = 0;
    int           rd_idx = 0;

    logic [W-1:0] rx_data [2048];
    logic         rx_last [2048];
    int           rx_n = 0;

    int           rd_on_empty = 0;
    int           occ_over    = 0;
    int           unstable    = 0;
    logic         prev_stall  = 1'b0;
    logic [W-1:0] prev_data   = '0;

    always #5 r_clk = ~r_clk;

    assign empty = (rd_idx == wr_idx);

    fifo_stream_reader #(
        .WIDTH     (W),
        .BUF_DEPTH (BD),
        .BURST_LEN (BL)
    ) dut (
        .r_clk    (r_clk),
        .r_rst_n  (r_rst_n),
        .enable   (enable),
        .empty    (empty),
        .data_out (data_out),
        .RD_EN    (RD_EN),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .busy     (busy),
        .beat_cnt (beat_cnt)
    );

    // FIFO model: registered read data, flushed while reset is held
    always @(posedge r_clk) begin
        if (!r_rst_n) begin
            rd_idx   <= wr_idx;
            data_out <= '0;
        end else if (RD_EN && !empty) begin
            data_out <= fifo_data[rd_idx];
            rd_idx   <= rd_idx + 1;
        end
    end

    // stream monitor and invariant counters
    always @(posedge r_clk) begin
        if (!r_rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (RD_EN && empty) rd_on_empty <= rd_on_empty + 1;
            if (int'(dut.u_buf.occ) > BD) occ_over <= occ_over + 1;
            if (prev_stall && (!m_valid || m_data !== prev_data)) unstable <= unstable + 1;
            prev_stall <= m_valid && !m_ready;
            prev_data  <= m_data;
            if (m_valid && m_ready) begin
                rx_data[rx_n] <= m_data;
                rx_last[rx_n] <= m_last;
                rx_n          <= rx_n + 1;
            end
        end
    end

    task automatic push_word(input logic [W-1:0] v);
        fifo_data[wr_idx] = v;
        wr_idx++;
    endtask

    task automatic test_reset;
        r_rst_n = 1'b0;
        repeat (2) @(negedge r_clk);
        #1;
        checks++; if (RD_EN !== 1'b0)   begin failures++; $display("FAIL reset_rd_en got=%0b exp=0", RD_EN); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
        checks++; if (m_data !== '0)    begin failures++; $display("FAIL reset_m_data got=%0h exp=0", m_data); end
        checks++; if (m_last !== 1'b0)  begin failures++; $display("FAIL reset_m_last got=%0b exp=0", m_last); end
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (beat_cnt !== '0)  begin failures++; $display("FAIL reset_beat_cnt got=%0d exp=0", beat_cnt); end
        @(negedge r_clk);
        r_rst_n = 1'b1;
        m_ready = 1'b1;
        @(negedge r_clk);
    endtask

    task automatic test_stream;
        int base;
        base = rx_n;
        for (int i = 0; i < 8; i++) push_word(W'(i));
        enable = 1'b1;
        for (int k = 0; k < 14; k++) begin
            #1;
            checks++; if (RD_EN !== (k < 8)) begin failures++; $display("FAIL stream_rd_en cycle=%0d got=%0b exp=%0b", k, RD_EN, (k < 8)); end
            checks++; if (m_valid !== (k >= 2 && k < 10)) begin failures++; $display("FAIL stream_m_valid cycle=%0d got=%0b exp=%0b", k, m_valid, (k >= 2 && k < 10)); end
            if (k >= 2 && k < 10) begin
                checks++; if (m_data !== W'(k - 2)) begin failures++; $display("FAIL stream_m_data cycle=%0d got=%0h exp=%0h", k, m_data, k - 2); end
            end
            @(negedge r_clk);
        end
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stream_busy_end got=%0b exp=0", busy); end
        checks++; if (rx_n !== base + 8) begin failures++; $display("FAIL stream_count got=%0d exp=%0d", rx_n - base, 8); end
        checks++; if (rx_last[base + 3] !== 1'b1) begin failures++; $display("FAIL stream_last3 got=%0b exp=1", rx_last[base + 3]); end
        checks++; if (rx_last[base + 7] !== 1'b1) begin failures++; $display("FAIL stream_last7 got=%0b exp=1", rx_last[base + 7]); end
        checks++; if (rx_last[base] !== 1'b0) begin failures++; $display("FAIL stream_last0 got=%0b exp=0", rx_last[base]); end
        @(negedge r_clk);
    endtask

    task automatic test_backpressure;
        int base;
        int n;
        base    = rx_n;
        n       = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(W'(32'h10 + i));
        for (int k = 0; k < 10; k++) begin
            #1;
            if (RD_EN) n++;
            @(negedge r_clk);
        end
        #1;
        checks++; if (n !== 4) begin failures++; $display("FAIL bp_reads got=%0d exp=4", n); end
        checks++; if (RD_EN !== 1'b0) begin failures++; $display("FAIL bp_rd_en got=%0b exp=0", RD_EN); end
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL bp_m_valid got=%0b exp=1", m_valid); end
        checks++; if (m_data !== 32'h10) begin failures++; $display("FAIL bp_m_data got=%0h exp=10", m_data); end
        checks++; if (dut.u_buf.occ !== 3'd4) begin failures++; $display("FAIL bp_occ got=%0d exp=4", dut.u_buf.occ); end
        m_ready = 1'b1;
        for (int c = 0; c < 40 && rx_n < base + 8; c++) @(negedge r_clk);
        checks++; if (rx_n !== base + 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", rx_n - base); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (rx_data[base + i] !== W'(32'h10 + i)) begin failures++; $display("FAIL bp_data idx=%0d got=%0h exp=%0h", i, rx_data[base + i], 32'h10 + i); end
        end
        for (int c = 0; c < 20 && busy; c++) @(negedge r_clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_busy_end got=%0b exp=0", busy); end
        checks++; if (unstable !== 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", unstable); end
        @(negedge r_clk);
    endtask

    task automatic test_burst;
        int base;
        base = rx_n;
        for (int i = 0; i < 10; i++) push_word(W'(32'h20 + i));
        for (int c = 0; c < 40 && rx_n < base + 10; c++) @(negedge r_clk);
        checks++; if (rx_n !== base + 10) begin failures++; $display("FAIL burst_count got=%0d exp=10", rx_n - base); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (rx_last[base + i] !== (i == 3 || i == 7)) begin failures++; $display("FAIL burst_last beat=%0d got=%0b exp=%0b", i, rx_last[base + i], (i == 3 || i == 7)); end
        end
        repeat (2) @(negedge r_clk);
        #1;
        checks++; if (beat_cnt !== 3'd2) begin failures++; $display("FAIL burst_beat_cnt got=%0d exp=2", beat_cnt); end
        push_word(32'h2A);
        push_word(32'h2B);
        for (int c = 0; c < 20 && rx_n < base + 12; c++) @(negedge r_clk);
        checks++; if (rx_n !== base + 12) begin failures++; $display("FAIL burst_tail_count got=%0d exp=12", rx_n - base); end
        checks++; if (rx_last[base + 10] !== 1'b0) begin failures++; $display("FAIL burst_tail_last0 got=%0b exp=0", rx_last[base + 10]); end
        checks++; if (rx_last[base + 11] !== 1'b1) begin failures++; $display("FAIL burst_tail_last1 got=%0b exp=1", rx_last[base + 11]); end
        checks++; if (rx_data[base + 11] !== 32'h2B) begin failures++; $display("FAIL burst_tail_data got=%0h exp=2b", rx_data[base + 11]); end
        repeat (3) @(negedge r_clk);
        #1;
        checks++; if (beat_cnt !== 3'd0) begin failures++; $display("FAIL burst_wrap got=%0d exp=0", beat_cnt); end
        @(negedge r_clk);
    endtask

    task automatic test_drain;
        int base;
        int n;
        base   = rx_n;
        n      = 0;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) push_word(W'(32'h30 + i));
        @(negedge r_clk);
        enable = 1'b1;
        #1;
        checks++; if (RD_EN !== 1'b1) begin failures++; $display("FAIL drain_rd_en_on got=%0b exp=1", RD_EN); end
        @(negedge r_clk);
        enable = 1'b0;
        #1;
        checks++; if (RD_EN !== 1'b0) begin failures++; $display("FAIL drain_rd_en_off got=%0b exp=0", RD_EN); end
        @(negedge r_clk);
        #1;
        checks++; if (dut.state !== DRAIN) begin failures++; $display("FAIL drain_state got=%0d exp=%0d", dut.state, DRAIN); end
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL drain_m_valid got=%0b exp=1", m_valid); end
        checks++; if (m_data !== 32'h30) begin failures++; $display("FAIL drain_m_data got=%0h exp=30", m_data); end
        for (int k = 0; k < 6; k++) begin
            @(negedge r_clk);
            #1;
            if (RD_EN) n++;
        end
        checks++; if (n !== 0) begin failures++; $display("FAIL drain_no_reads got=%0d exp=0", n); end
        checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL drain_idle got=%0d exp=%0d", dut.state, IDLE); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drain_busy got=%0b exp=0", busy); end
        checks++; if (rx_n !== base + 1) begin failures++; $display("FAIL drain_count got=%0d exp=1", rx_n - base); end
        checks++; if (rx_data[base] !== 32'h30) begin failures++; $display("FAIL drain_data got=%0h exp=30", rx_data[base]); end
        @(negedge r_clk);
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 6; i++) push_word(W'(32'h40 + i));
        @(negedge r_clk);
        enable = 1'b1;
        repeat (4) @(negedge r_clk);
        @(posedge r_clk);
        #3;
        r_rst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL arst_m_valid got=%0b exp=0", m_valid); end
        checks++; if (RD_EN !== 1'b0) begin failures++; $display("FAIL arst_rd_en got=%0b exp=0", RD_EN); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%0b exp=0", busy); end
        checks++; if (beat_cnt !== '0) begin failures++; $display("FAIL arst_beat_cnt got=%0d exp=0", beat_cnt); end
        checks++; if (m_data !== '0) begin failures++; $display("FAIL arst_m_data got=%0h exp=0", m_data); end
        repeat (2) @(negedge r_clk);
        r_rst_n = 1'b1;
        @(negedge r_clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy_after got=%0b exp=0", busy); end
        @(negedge r_clk);
    endtask

    task automatic test_random;
        int base;
        base = rx_n;
        for (int i = 0; i < 1000; i++) push_word(W'(32'hA500_0000 + i * 37));
        enable = 1'b1;
        for (int c = 0; c < 6000 && rx_n < base + 1000; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            @(negedge r_clk);
        end
        m_ready = 1'b1;
        checks++; if (rx_n !== base + 1000) begin failures++; $display("FAIL rand_count got=%0d exp=1000", rx_n - base); end
        for (int i = 0; i < 1000; i++) begin
            checks++; if (rx_data[base + i] !== W'(32'hA500_0000 + i * 37)) begin failures++; $display("FAIL rand_data idx=%0d got=%0h exp=%0h", i, rx_data[base + i], 32'hA500_0000 + i * 37); end
        end
        checks++; if (rd_on_empty !== 0) begin failures++; $display("FAIL rand_rd_on_empty got=%0d exp=0", rd_on_empty); end
        checks++; if (occ_over !== 0) begin failures++; $display("FAIL rand_occ_over got=%0d exp=0", occ_over); end
        checks++; if (unstable !== 0) begin failures++; $display("FAIL rand_unstable got=%0d exp=0", unstable); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_burst;
        test_drain;
        test_async_reset;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
